// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - I/D requester, response and memory-port signals of mem_bus_arbiter
//
// Purpose: bundles everything between the core pipeline, the arbiter and the
// memory/MMIO block so the arbiter takes a single bus port.
// Ports (signals):
//   i_req_* / d_req_*   requester commands (valid/ready/addr/wen/wdata)
//   i_resp_* / d_resp_* per-requester response strobe and timeout flag
//   resp_rdata          shared response read data
//   mem_cmd_* / mem_*   command to memory and its response
// Modports:
//   slave  - the arbiter's view
//   master - the surrounding core + memory view (drives requests and memory replies)
interface mem_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  i_req_valid;
    logic                  i_req_ready;
    logic [ADDR_WIDTH-1:0] i_req_addr;
    logic                  i_req_wen;
    logic [DATA_WIDTH-1:0] i_req_wdata;
    logic                  i_resp_valid;
    logic                  i_resp_err;

    logic                  d_req_valid;
    logic                  d_req_ready;
    logic [ADDR_WIDTH-1:0] d_req_addr;
    logic                  d_req_wen;
    logic [DATA_WIDTH-1:0] d_req_wdata;
    logic                  d_resp_valid;
    logic                  d_resp_err;

    logic [DATA_WIDTH-1:0] resp_rdata;

    logic                  mem_cmd_valid;
    logic                  mem_cmd_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wen;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  i_req_valid, i_req_addr, i_req_wen, i_req_wdata,
        input  d_req_valid, d_req_addr, d_req_wen, d_req_wdata,
        input  mem_cmd_ready, mem_resp_valid, mem_rdata,
        output i_req_ready, i_resp_valid, i_resp_err,
        output d_req_ready, d_resp_valid, d_resp_err,
        output resp_rdata,
        output mem_cmd_valid, mem_addr, mem_wen, mem_wdata
    );

    modport master (
        output i_req_valid, i_req_addr, i_req_wen, i_req_wdata,
        output d_req_valid, d_req_addr, d_req_wen, d_req_wdata,
        output mem_cmd_ready, mem_resp_valid, mem_rdata,
        input  i_req_ready, i_resp_valid, i_resp_err,
        input  d_req_ready, d_resp_valid, d_resp_err,
        input  resp_rdata,
        input  mem_cmd_valid, mem_addr, mem_wen, mem_wdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin I/D arbiter for the single memory port, with response watchdog
//
// Purpose: grants one of the instruction-fetch (I) or data (D) requesters,
// issues its command to memory, waits for the single response and routes it
// back to the owner. If memory stays silent for TIMEOUT cycles after the
// command handshake the owner gets an error response instead.
// Ports:
//   clk    - system clock, all state on posedge
//   reset  - synchronous, active-high
//   bus    - mem_bus_arbiter_if.slave: requester, response and memory signals
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input logic                clk,
    input logic                reset,
    mem_bus_arbiter_if.slave   bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    state_t                state_q, state_d;
    owner_t                owner_q, owner_d;
    owner_t                last_q, last_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wen_q, wen_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  grant_i;
    logic                  grant_d;
    logic                  cmd_valid;
    logic                  resp_fire;
    logic                  resp_err;
    logic [DATA_WIDTH-1:0] resp_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            owner_q <= OWN_I;
            last_q  <= OWN_D;   // I wins the first tie after reset
            timer_q <= '0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            timer_q <= timer_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        timer_d    = timer_q;
        addr_d     = addr_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        cmd_valid  = 1'b0;
        resp_fire  = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;

        case (state_q)
            S_IDLE: begin
                // Grant depends only on requester valids and last_q, so no
                // mem_* input reaches the *_req_ready outputs.
                if (bus.i_req_valid && (!bus.d_req_valid || last_q == OWN_D)) begin
                    grant_i = 1'b1;
                end else if (bus.d_req_valid) begin
                    grant_d = 1'b1;
                end

                if (grant_i) begin
                    addr_d  = bus.i_req_addr;
                    wen_d   = bus.i_req_wen;
                    wdata_d = bus.i_req_wdata;
                    owner_d = OWN_I;
                    last_d  = OWN_I;
                    state_d = S_ISSUE;
                end else if (grant_d) begin
                    addr_d  = bus.d_req_addr;
                    wen_d   = bus.d_req_wen;
                    wdata_d = bus.d_req_wdata;
                    owner_d = OWN_D;
                    last_d  = OWN_D;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                cmd_valid = 1'b1;
                if (bus.mem_cmd_ready) begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                // A real response in the last watchdog cycle still wins over the error.
                if (bus.mem_resp_valid) begin
                    resp_fire  = 1'b1;
                    resp_rdata = bus.mem_rdata;
                    state_d    = S_IDLE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    resp_fire  = 1'b1;
                    resp_err   = 1'b1;
                    state_d    = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.i_req_ready   = grant_i;
    assign bus.d_req_ready   = grant_d;
    assign bus.i_resp_valid  = resp_fire && (owner_q == OWN_I);
    assign bus.d_resp_valid  = resp_fire && (owner_q == OWN_D);
    assign bus.i_resp_err    = resp_err && (owner_q == OWN_I);
    assign bus.d_resp_err    = resp_err && (owner_q == OWN_D);
    assign bus.resp_rdata    = resp_rdata;
    assign bus.mem_cmd_valid = cmd_valid;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wen       = wen_q;
    assign bus.mem_wdata     = wdata_q;
endmodule
